gate_exerciser: RTL
===================

# gate_exerciser

Self-checking stimulus/response engine for a 2-input combinational gate under test (GUT). It drives all four input vectors onto the GUT, waits a programmable settle time, samples the GUT output and compares it against a selected reference function. It reports pass/fail, an error count and a per-vector failure mask. It sits on the opposite side of a gate's a/b/o interface and serves as the on-chip checker for the gate-level blocks in this design.

## Interface
- SETTLE_CYC, default 2: cycles each vector is held before the GUT output is sampled; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a test run; honoured only in IDLE.
- func_sel  in  3  expected function. 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR; 110/111 illegal.
- gate_a  out  1  GUT input a.
- gate_b  out  1  GUT input b.
- gate_o  in  1  GUT output.
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 = all four vectors matched; valid from done, held until next accepted start.
- err_cnt  out  3  mismatch count 0..4; held like pass.
- fail_mask  out  4  bit k set = vector k ({a,b}=k) mismatched; held like pass.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge N:
  - Latch func_sel.
  - Clear err_cnt, fail_mask and pass.
  - With a legal code, go to RUN.
  - With an illegal code, go to DONE directly. No vectors are driven; the result is pass=0, err_cnt=0, fail_mask=0.
- RUN:
  - Vector index k counts 0..3; {gate_a,gate_b}=k.
  - A settle counter counts SETTLE_CYC cycles per vector.
  - On the last settle cycle's edge:
    - Compare gate_o with gate_ref(func, a, b).
    - On mismatch, set fail_mask[k] and increment err_cnt.
    - Advance k in the same edge.
  - After k=3 is sampled, go to DONE.
- DONE (one cycle):
  - done=1, busy=0, gate_a=gate_b=0.
  - pass=(err_cnt==0) && legal func.
  - Go to IDLE.
- start while busy or in DONE is ignored; it is not queued.
- Changes to func_sel during a run have no effect, because the code is latched at start.
- Reset: asynchronous to IDLE. All outputs go to 0 immediately (gate_a, gate_b, busy, done, pass, err_cnt, fail_mask).
- Reset mid-run: the run is aborted, no done pulse, results are cleared.

## Timing
- start sampled at edge N. At edge N+1: busy=1, vector 0 driven.
- Vector k is driven from edge N+1+k·S, where S=SETTLE_CYC, and sampled at edge N+1+(k+1)·S.
- Vector 3 is sampled at edge N+1+4S. At the same edge: busy falls, gate_a/b go to 0, pass/err_cnt/fail_mask take final values.
- done is high for exactly the cycle following edge N+1+4S.
- Back in IDLE at edge N+2+4S. A start held high across this edge launches the next run.
- Illegal func_sel: done is high for the cycle after edge N+1; busy never rises.
- All outputs are registered; there is no combinational path from gate_o or start to any output.

## Structure
- Package gate_pkg holds:
  - func_sel code constants (FN_AND..FN_XNOR).
  - FSM state encoding (IDLE, RUN, DONE).
  - Vector count constant NVEC=4.
- Sub-module gate_ref: purely combinational, 3-bit func plus a and b in, expected out, plus a legal flag.
- Top level holds the FSM, the vector index, the settle counter and the result registers.

## Test plan
- GUT=AND, func_sel=000, S=2, start at edge 0:
  - vectors 00,01,10,11 applied at edges 1,3,5,7;
  - done high in the cycle after edge 9, pass=1, err_cnt=0, fail_mask=0000.
- GUT=AND, func_sel=010 (XOR):
  - mismatches on vectors 01, 10 and 11;
  - pass=0, err_cnt=3, fail_mask=1110.
- GUT output stuck at 1, func_sel=011 (NAND):
  - result pass=0, err_cnt=1, fail_mask=1000.
- func_sel=111, start:
  - done in the cycle after edge 1, busy never high, pass=0, err_cnt=0;
  - gate_a and gate_b stay 0.
- Mid-run reset and retrigger:
  - rst_n low during vector 2, asynchronously: all outputs 0 before the next edge, and no done pulse.
  - After release, start with func_sel=000: full run, pass=1.
  - A second start pulse while busy is ignored: exactly one done pulse.
- S=1 back-to-back runs, start held high:
  - runs restart every 6 cycles;
  - pass, err_cnt and fail_mask are stable between consecutive done pulses.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared constants for the 2-input gate exerciser: function codes, FSM
// state encoding and vector count.
package gate_pkg;

  localparam logic [2:0] FN_AND  = 3'b000;
  localparam logic [2:0] FN_OR   = 3'b001;
  localparam logic [2:0] FN_XOR  = 3'b010;
  localparam logic [2:0] FN_NAND = 3'b011;
  localparam logic [2:0] FN_NOR  = 3'b100;
  localparam logic [2:0] FN_XNOR = 3'b101;

  localparam int NVEC = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref.sv
// Reference model of the gate under test: expected output for a
// function code and input pair, plus a flag for legal codes.
module gate_ref
  import gate_pkg::*;
(
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  output logic       expected,
  output logic       legal
);

  always_comb begin
    expected = 1'b0;
    legal    = 1'b1;
    case (func)
      FN_AND:  expected = a & b;
      FN_OR:   expected = a | b;
      FN_XOR:  expected = a ^ b;
      FN_NAND: expected = ~(a & b);
      FN_NOR:  expected = ~(a | b);
      FN_XNOR: expected = ~(a ^ b);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_exerciser.sv
// Drives all four a/b vectors onto a gate under test, samples its output
// after a settle time and accumulates pass/fail results.
//
//   state | meaning
//   IDLE  | waiting; an accepted start arms a launch on the following edge
//   RUN   | applying vectors 0..3, settle timer per vector
//   DONE  | one-cycle done pulse, results final
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [1:0] LAST_VEC  = 2'(NVEC - 1);

  state_t     state, state_nx;
  logic       armed;
  logic [2:0] func_q;
  logic [1:0] vec_k;
  logic [3:0] settle_cnt;
  logic       exp_o;
  logic       func_legal;
  logic       launch;
  logic       sample;
  logic       last_sample;
  logic       mismatch;
  logic       accept;

  gate_ref u_ref (
    .func    (func_q),
    .a       (vec_k[1]),
    .b       (vec_k[0]),
    .expected(exp_o),
    .legal   (func_legal)
  );

  assign gate_a   = vec_k[1];
  assign gate_b   = vec_k[0];
  assign mismatch = gate_o ^ exp_o;
  // A start is taken on any edge that leaves the FSM in IDLE, including the
  // DONE->IDLE edge, so a held start chains runs with no gap.
  assign accept   = start && (state_nx == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    launch      = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    case (state)
      IDLE: begin
        if (armed) begin
          launch   = 1'b1;
          state_nx = func_legal ? RUN : DONE;
        end
      end
      RUN: begin
        if (settle_cnt == 4'd1) begin
          sample = 1'b1;
          if (vec_k == LAST_VEC) begin
            last_sample = 1'b1;
            state_nx    = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      func_q     <= 3'd0;
      vec_k      <= 2'd0;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 3'd0;
      fail_mask  <= 4'd0;
    end else begin
      armed <= accept;
      done  <= 1'b0;
      if (accept) begin
        func_q    <= func_sel;
        pass      <= 1'b0;
        err_cnt   <= 3'd0;
        fail_mask <= 4'd0;
      end
      if (launch) begin
        vec_k      <= 2'd0;
        settle_cnt <= SETTLE_LD;
        busy       <= func_legal;
        done       <= ~func_legal;
      end
      if (state == RUN) begin
        if (sample) begin
          if (mismatch) begin
            fail_mask[vec_k] <= 1'b1;
            err_cnt          <= err_cnt + 3'd1;
          end
          // vec_k wraps 3->0 so the gate inputs return low at the end of a run
          vec_k      <= vec_k + 2'd1;
          settle_cnt <= SETTLE_LD;
          if (last_sample) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_cnt == 3'd0) && !mismatch;
          end
        end else begin
          settle_cnt <= settle_cnt - 4'd1;
        end
      end
    end
  end

endmodule
